// File: rtl/burst_ram_arbiter.sv
// Arbitrates several cache clients onto one BurstRAM port: one registered grant at a time,
// round-robin or fixed priority, with a sticky hold-timeout flag.
module burst_ram_arbiter #(
    parameter int NUM_CLIENTS             = 2,
    parameter int RAM_DEPTH_BITWIDTH      = 4,
    parameter int RAM_BURST_DATA_BITWIDTH = 64,
    parameter int ARB_MODE                = 0,
    parameter int HOLD_TIMEOUT            = 255
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic [NUM_CLIENTS-1:0]                            req,
    input  logic [NUM_CLIENTS-1:0]                            cli_busy,
    input  logic [NUM_CLIENTS-1:0]                            cli_cmd,
    input  logic [NUM_CLIENTS-1:0]                            cli_cmd_en,
    input  logic [NUM_CLIENTS*RAM_DEPTH_BITWIDTH-1:0]         cli_addr,
    input  logic [NUM_CLIENTS*RAM_BURST_DATA_BITWIDTH-1:0]    cli_wr_data,
    input  logic [NUM_CLIENTS*RAM_BURST_DATA_BITWIDTH/8-1:0]  cli_data_mask,
    output logic                                              br_cmd,
    output logic                                              br_cmd_en,
    output logic [RAM_DEPTH_BITWIDTH-1:0]                     br_addr,
    output logic [RAM_BURST_DATA_BITWIDTH-1:0]                br_wr_data,
    output logic [RAM_BURST_DATA_BITWIDTH/8-1:0]              br_data_mask,
    input  logic [RAM_BURST_DATA_BITWIDTH-1:0]                br_rd_data,
    input  logic                                              br_rd_data_valid,
    input  logic                                              br_busy,
    output logic [RAM_BURST_DATA_BITWIDTH-1:0]                cli_rd_data,
    output logic [NUM_CLIENTS-1:0]                            grant,
    output logic [NUM_CLIENTS-1:0]                            cli_rd_data_valid,
    output logic                                              timeout_err
);
    localparam int AW = RAM_DEPTH_BITWIDTH;
    localparam int DW = RAM_BURST_DATA_BITWIDTH;
    localparam int MW = RAM_BURST_DATA_BITWIDTH / 8;
    localparam int IW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam int HW = (HOLD_TIMEOUT > 0) ? $clog2(HOLD_TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ACTIVATE = 2'd1,
        S_WAIT     = 2'd2
    } state_t;

    state_t                 state, state_nx;
    logic [NUM_CLIENTS-1:0] grant_nx;
    logic [IW-1:0]          last_grant, last_grant_nx;
    logic [IW-1:0]          winner, cand;
    logic                   win_found;
    logic [HW-1:0]          hold_cnt, hold_cnt_nx;
    logic                   timeout_nx;

    // Loops run backwards so the highest-priority candidate is the last one assigned.
    always_comb begin
        winner    = '0;
        cand      = '0;
        win_found = 1'b0;
        if (ARB_MODE == 1) begin
            for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
                if (req[i]) begin
                    winner    = IW'(i);
                    win_found = 1'b1;
                end
            end
        end else begin
            for (int k = NUM_CLIENTS; k >= 1; k--) begin
                cand = IW'((int'(last_grant) + k) % NUM_CLIENTS);
                if (req[cand]) begin
                    winner    = cand;
                    win_found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_nx      = state;
        grant_nx      = grant;
        last_grant_nx = last_grant;
        hold_cnt_nx   = hold_cnt;
        timeout_nx    = timeout_err;
        case (state)
            S_IDLE: begin
                grant_nx = '0;
                if (win_found && !br_busy) begin
                    grant_nx      = {{(NUM_CLIENTS-1){1'b0}}, 1'b1} << winner;
                    last_grant_nx = winner;
                    state_nx      = S_ACTIVATE;
                end
            end
            S_ACTIVATE: begin
                hold_cnt_nx = '0;
                state_nx    = S_WAIT;
            end
            S_WAIT: begin
                if ((cli_busy & grant) == '0) begin
                    grant_nx = '0;
                    state_nx = S_IDLE;
                end else begin
                    if (hold_cnt != '1) hold_cnt_nx = hold_cnt + 1'b1;
                    if (HOLD_TIMEOUT != 0 && (int'(hold_cnt) + 1) >= HOLD_TIMEOUT) timeout_nx = 1'b1;
                end
            end
            default: begin
                grant_nx = '0;
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            grant       <= '0;
            last_grant  <= IW'(NUM_CLIENTS - 1);
            hold_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nx;
            grant       <= grant_nx;
            last_grant  <= last_grant_nx;
            hold_cnt    <= hold_cnt_nx;
            timeout_err <= timeout_nx;
        end
    end

    // AND-OR mux on the one-hot grant: everything reads zero when nobody holds the RAM.
    always_comb begin
        br_cmd       = 1'b0;
        br_cmd_en    = 1'b0;
        br_addr      = '0;
        br_wr_data   = '0;
        br_data_mask = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (grant[i]) begin
                br_cmd       = br_cmd       | cli_cmd[i];
                br_cmd_en    = br_cmd_en    | cli_cmd_en[i];
                br_addr      = br_addr      | cli_addr[i*AW +: AW];
                br_wr_data   = br_wr_data   | cli_wr_data[i*DW +: DW];
                br_data_mask = br_data_mask | cli_data_mask[i*MW +: MW];
            end
        end
    end

    assign cli_rd_data       = br_rd_data;
    assign cli_rd_data_valid = grant & {NUM_CLIENTS{br_rd_data_valid}};

endmodule

// File: tb/tb_burst_ram_arbiter.sv
// Directed bench: a 2-client round-robin arbiter (hold timeout 8) and a 4-client fixed-priority one.
module tb_burst_ram_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [1:0]   req_a = '0, busy_a = '0, cmd_a = '0, cmd_en_a = '0;
    logic [7:0]   addr_a = '0;
    logic [127:0] wd_a = '0;
    logic [15:0]  mask_a = '0;
    logic         br_cmd_a, br_cmd_en_a;
    logic [3:0]   br_addr_a;
    logic [63:0]  br_wr_data_a, br_rd_data_a = '0, cli_rd_data_a;
    logic [7:0]   br_mask_a;
    logic         br_rd_valid_a = 1'b0, br_busy_a = 1'b0;
    logic [1:0]   grant_a, crv_a;
    logic         terr_a;

    logic [3:0]   req_b = '0, busy_b = '0, cmd_b = '0, cmd_en_b = '0;
    logic [15:0]  addr_b = '0;
    logic [255:0] wd_b = '0;
    logic [31:0]  mask_b = '0;
    logic         br_cmd_b, br_cmd_en_b;
    logic [3:0]   br_addr_b;
    logic [63:0]  br_wr_data_b, cli_rd_data_b;
    logic [7:0]   br_mask_b;
    logic [3:0]   grant_b, crv_b;
    logic         terr_b;

    logic [1:0] exp_seq [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

    burst_ram_arbiter #(.NUM_CLIENTS(2), .ARB_MODE(0), .HOLD_TIMEOUT(8)) dut_a (
        .clk(clk), .rst(rst), .req(req_a), .cli_busy(busy_a), .cli_cmd(cmd_a),
        .cli_cmd_en(cmd_en_a), .cli_addr(addr_a), .cli_wr_data(wd_a), .cli_data_mask(mask_a),
        .br_cmd(br_cmd_a), .br_cmd_en(br_cmd_en_a), .br_addr(br_addr_a),
        .br_wr_data(br_wr_data_a), .br_data_mask(br_mask_a), .br_rd_data(br_rd_data_a),
        .br_rd_data_valid(br_rd_valid_a), .br_busy(br_busy_a), .cli_rd_data(cli_rd_data_a),
        .grant(grant_a), .cli_rd_data_valid(crv_a), .timeout_err(terr_a));

    burst_ram_arbiter #(.NUM_CLIENTS(4), .ARB_MODE(1)) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .cli_busy(busy_b), .cli_cmd(cmd_b),
        .cli_cmd_en(cmd_en_b), .cli_addr(addr_b), .cli_wr_data(wd_b), .cli_data_mask(mask_b),
        .br_cmd(br_cmd_b), .br_cmd_en(br_cmd_en_b), .br_addr(br_addr_b),
        .br_wr_data(br_wr_data_b), .br_data_mask(br_mask_b), .br_rd_data(64'h0),
        .br_rd_data_valid(1'b0), .br_busy(1'b0), .cli_rd_data(cli_rd_data_b),
        .grant(grant_b), .cli_rd_data_valid(crv_b), .timeout_err(terr_b));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cmd_en_a = 2'b11;
        addr_a = 8'hA5;
        wd_a = {64'hFFFF_0000_FFFF_0000, 64'h1234_5678_9ABC_DEF0};
        step(); step();
        vectors++; if (grant_a !== 2'b00) begin miscompares++; $display("FAIL reset_grant_a got %b want 00", grant_a); end
        vectors++; if (grant_b !== 4'b0000) begin miscompares++; $display("FAIL reset_grant_b got %b want 0000", grant_b); end
        vectors++; if (terr_a !== 1'b0) begin miscompares++; $display("FAIL reset_terr got %b want 0", terr_a); end
        vectors++; if (br_cmd_en_a !== 1'b0 || br_addr_a !== 4'h0 || br_wr_data_a !== 64'h0)
            begin miscompares++; $display("FAIL reset_br_zero got en=%b addr=%h wd=%h want 0", br_cmd_en_a, br_addr_a, br_wr_data_a); end
        rst = 1'b0;
        step();
        vectors++; if (grant_a !== 2'b00 || br_cmd_en_a !== 1'b0)
            begin miscompares++; $display("FAIL idle_no_req got grant=%b en=%b want 00/0", grant_a, br_cmd_en_a); end
        cmd_en_a = 2'b00; addr_a = '0; wd_a = '0;
    endtask

    task automatic test_fixed_priority();
        int rises = 0;
        logic [3:0] prev = '0;
        req_b = 4'b1110;
        for (int c = 0; c < 12; c++) begin
            step();
            vectors++;
            if (grant_b !== 4'b0000 && grant_b !== 4'b0010)
                begin miscompares++; $display("FAIL fixed_grant cycle %0d got %b want 0010 or 0000", c, grant_b); end
            if (grant_b != 4'b0000 && prev == 4'b0000) rises++;
            prev = grant_b;
        end
        vectors++; if (rises !== 4) begin miscompares++; $display("FAIL fixed_grant_count got %0d want 4", rises); end
        req_b = '0;
        step(); step(); step();
    endtask

    task automatic test_round_robin();
        logic [1:0] prev = '0;
        int n = 0, hi = 0, lo = 0, falls = 0, busy_left = 0;
        req_a = 2'b11;
        for (int c = 0; c < 60 && falls < 4; c++) begin
            step();
            if (grant_a != 2'b00 && prev == 2'b00) begin
                vectors++;
                if (n < 4 && grant_a !== exp_seq[n])
                    begin miscompares++; $display("FAIL rr_order grant %0d got %b want %b", n, grant_a, exp_seq[n]); end
                if (n > 0) begin
                    vectors++;
                    if (lo !== 1) begin miscompares++; $display("FAIL rr_idle_gap got %0d want 1", lo); end
                end
                n++;
                hi = 0;
                busy_left = 4;
            end else if (busy_left > 0) begin
                busy_left--;
            end
            busy_a = (busy_left > 0) ? grant_a : 2'b00;
            if (grant_a != 2'b00) hi++;
            else begin
                if (prev != 2'b00) begin
                    vectors++;
                    if (hi !== 5) begin miscompares++; $display("FAIL rr_hold_len got %0d want 5", hi); end
                    falls++;
                    lo = 1;
                end else lo++;
            end
            prev = grant_a;
        end
        req_a = 2'b00;
        busy_a = 2'b00;
        vectors++; if (falls !== 4) begin miscompares++; $display("FAIL rr_complete got %0d grants want 4", falls); end
        step();
    endtask

    task automatic test_br_busy();
        br_busy_a = 1'b1;
        req_a = 2'b11;
        for (int c = 0; c < 3; c++) begin
            step();
            vectors++; if (grant_a !== 2'b00) begin miscompares++; $display("FAIL br_busy_block cycle %0d got %b want 00", c, grant_a); end
        end
        br_busy_a = 1'b0;
        step();
        vectors++; if (grant_a !== 2'b01) begin miscompares++; $display("FAIL br_busy_release got %b want 01", grant_a); end
        req_a = 2'b00;
        step(); step();
        vectors++; if (grant_a !== 2'b00) begin miscompares++; $display("FAIL br_busy_end got %b want 00", grant_a); end
    endtask

    task automatic test_datapath();
        req_a = 2'b10; busy_a = 2'b10;
        addr_a = {4'hA, 4'h5}; cmd_en_a = 2'b11; cmd_a = 2'b10;
        wd_a = {64'hDEAD_BEEF_CAFE_F00D, 64'h1111_2222_3333_4444};
        mask_a = {8'hF0, 8'h0F};
        step();
        vectors++; if (grant_a !== 2'b10) begin miscompares++; $display("FAIL dp_grant got %b want 10", grant_a); end
        #1;
        vectors++; if (br_addr_a !== 4'hA || br_cmd_en_a !== 1'b1 || br_cmd_a !== 1'b1)
            begin miscompares++; $display("FAIL dp_cmd got addr=%h en=%b cmd=%b want a/1/1", br_addr_a, br_cmd_en_a, br_cmd_a); end
        vectors++; if (br_wr_data_a !== 64'hDEAD_BEEF_CAFE_F00D || br_mask_a !== 8'hF0)
            begin miscompares++; $display("FAIL dp_wdata got %h/%h want deadbeefcafef00d/f0", br_wr_data_a, br_mask_a); end
        step();
        br_rd_data_a = 64'h0123_4567_89AB_CDEF;
        br_rd_valid_a = 1'b1;
        #1;
        vectors++; if (crv_a !== 2'b10 || cli_rd_data_a !== 64'h0123_4567_89AB_CDEF)
            begin miscompares++; $display("FAIL dp_rvalid got %b/%h want 10/0123456789abcdef", crv_a, cli_rd_data_a); end
        br_rd_valid_a = 1'b0;
        #1;
        vectors++; if (crv_a !== 2'b00) begin miscompares++; $display("FAIL dp_rvalid_low got %b want 00", crv_a); end
        req_a = 2'b00; busy_a = 2'b00;
        step();
        vectors++; if (grant_a !== 2'b00 || br_cmd_en_a !== 1'b0 || br_addr_a !== 4'h0)
            begin miscompares++; $display("FAIL dp_release got grant=%b en=%b addr=%h want 00/0/0", grant_a, br_cmd_en_a, br_addr_a); end
        cmd_a = 2'b00;
    endtask

    task automatic test_timeout();
        req_a = 2'b01; busy_a = 2'b01; cmd_en_a = 2'b01;
        step();
        vectors++; if (grant_a !== 2'b01) begin miscompares++; $display("FAIL to_grant got %b want 01", grant_a); end
        for (int c = 1; c <= 8; c++) begin
            step();
            vectors++; if (terr_a !== 1'b0) begin miscompares++; $display("FAIL to_early after edge %0d got %b want 0", c, terr_a); end
        end
        step();
        vectors++; if (terr_a !== 1'b1) begin miscompares++; $display("FAIL to_set got %b want 1", terr_a); end
        req_a = 2'b00;
        step(); step(); step();
        vectors++; if (terr_a !== 1'b1 || grant_a !== 2'b01)
            begin miscompares++; $display("FAIL to_sticky got terr=%b grant=%b want 1/01", terr_a, grant_a); end
    endtask

    task automatic test_reset_mid_wait();
        rst = 1'b1;
        step();
        vectors++; if (grant_a !== 2'b00 || br_cmd_en_a !== 1'b0 || terr_a !== 1'b0)
            begin miscompares++; $display("FAIL rst_wait got grant=%b en=%b terr=%b want 00/0/0", grant_a, br_cmd_en_a, terr_a); end
        rst = 1'b0;
        busy_a = 2'b00;
        req_a = 2'b11;
        step();
        vectors++; if (grant_a !== 2'b01) begin miscompares++; $display("FAIL rst_first_grant got %b want 01", grant_a); end
        req_a = 2'b00;
        cmd_en_a = 2'b00;
    endtask

    initial begin
        test_reset();
        test_fixed_priority();
        test_round_robin();
        test_br_busy();
        test_datapath();
        test_timeout();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/burst_ram_arbiter.md
BURST_RAM_ARBITER -- requirements
Module: burst_ram_arbiter

Interface
REQ-001 SHALL have parameter NUM_CLIENTS, default 2, number of cache clients sharing one BurstRAM (legal range 2..8).
REQ-002 SHALL have parameter RAM_DEPTH_BITWIDTH, default 4, BurstRAM address width.
REQ-003 SHALL have parameter RAM_BURST_DATA_BITWIDTH, default 64, burst data width (multiple of 8).
REQ-004 SHALL have parameter ARB_MODE, default 0; 0 = round-robin, 1 = fixed priority (lowest index wins).
REQ-005 SHALL have parameter HOLD_TIMEOUT, default 255, max cycles a grant may stay in WAIT before timeout_err sets; 0 disables the check.
REQ-006 SHALL have port clk  in  1  clock; all state changes on rising edge.
REQ-007 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-008 SHALL have port req  in  NUM_CLIENTS  per-client access request, level.
REQ-009 SHALL have port cli_busy  in  NUM_CLIENTS  per-client "transaction in progress".
REQ-010 SHALL have ports cli_cmd, cli_cmd_en  in  NUM_CLIENTS each  per-client BurstRAM command/strobe.
REQ-011 SHALL have port cli_addr  in  NUM_CLIENTS*RAM_DEPTH_BITWIDTH  packed, client i at slice i.
REQ-012 SHALL have ports cli_wr_data  in  NUM_CLIENTS*RAM_BURST_DATA_BITWIDTH and cli_data_mask  in  NUM_CLIENTS*RAM_BURST_DATA_BITWIDTH/8  packed.
REQ-013 SHALL have ports br_cmd, br_cmd_en  out  1; br_addr  out  RAM_DEPTH_BITWIDTH; br_wr_data  out  RAM_BURST_DATA_BITWIDTH; br_data_mask  out  RAM_BURST_DATA_BITWIDTH/8.
REQ-014 SHALL have ports br_rd_data  in  RAM_BURST_DATA_BITWIDTH, br_rd_data_valid  in  1, br_busy  in  1.
REQ-015 SHALL have ports grant  out  NUM_CLIENTS (one-hot or zero, registered), cli_rd_data_valid  out  NUM_CLIENTS, timeout_err  out  1 (sticky).

Function
REQ-016 SHALL implement states IDLE, ACTIVATE, WAIT.
REQ-017 IDLE: if any req bit set and br_busy==0, SHALL register winner into grant and move to ACTIVATE; else stay IDLE with grant==0.
REQ-018 ACTIVATE: SHALL last exactly one cycle (client busy rise slot), then WAIT.
REQ-019 WAIT: when cli_busy[g]==0 for granted g, SHALL clear grant and return to IDLE on next edge.
REQ-020 Grant latency: req sampled at edge T -> grant visible after T; minimum one IDLE cycle between consecutive grants.
REQ-021 Round-robin: search begins at last_grant+1, wraps at NUM_CLIENTS-1 -> 0; last_grant updates on each grant.
REQ-022 Fixed priority: lowest-indexed asserted req wins; last_grant ignored.
REQ-023 When grant==0, br_cmd_en, br_cmd, br_addr, br_wr_data, br_data_mask SHALL be 0.
REQ-024 When grant[g]==1, br_* outputs SHALL combinationally equal client g's slices.
REQ-025 br_rd_data SHALL be broadcast; cli_rd_data_valid[i] = br_rd_data_valid AND grant[i].
REQ-026 req deassert during ACTIVATE/WAIT SHALL NOT end the grant; only cli_busy low in WAIT does.
REQ-027 Hold counter SHALL clear on entering WAIT, increment each WAIT cycle, saturate; reaching HOLD_TIMEOUT sets timeout_err (grant kept).
REQ-028 Simultaneous requests SHALL yield exactly one grant bit.

Reset
REQ-029 On rst: state IDLE, grant 0, last_grant NUM_CLIENTS-1 (client 0 first), hold counter 0, timeout_err 0, all br_* outputs 0.
REQ-030 rst mid-transaction SHALL drop grant and br_cmd_en on the next edge irrespective of cli_busy.

Verification
REQ-031 NUM_CLIENTS=2, ARB_MODE=0, req=2'b11 held, each client busy 4 cycles -> grants alternate 01,10,01,10 with one IDLE cycle between.
REQ-032 NUM_CLIENTS=4, ARB_MODE=1, req=4'b1110 -> grant=4'b0010 repeatedly; client 3 never granted while client 1 requests.
REQ-033 Client 1 granted, cli_addr slice 1 = 4'hA, cli_cmd_en=1 -> br_addr=4'hA, br_cmd_en=1; client 0 cli_cmd_en=1 ignored; br_rd_data_valid pulse -> cli_rd_data_valid=2'b10.
REQ-034 HOLD_TIMEOUT=8, cli_busy stuck high -> timeout_err=1 after 8th WAIT cycle, stays 1 until rst.
REQ-035 rst asserted in WAIT -> next cycle grant=0, br_cmd_en=0, state IDLE; first grant after release goes to client 0.
REQ-036 br_busy=1 in IDLE with req set -> no grant until br_busy=0.
